// File: rtl/maze_render_pipe.sv
// Two-stage maze pixel renderer: pixel -> cell mapping, then wall/player/fog lookup.
// Holds the maze bitmap and visited map; player highlight and optional fog-of-war.
module maze_render_pipe #(
    parameter int SIZE_X      = 40,
    parameter int SIZE_Y      = 20,
    parameter int CELL_LOG2_W = 4,
    parameter int CELL_LOG2_H = 4,
    parameter int ORIGIN_X    = 0,
    parameter int ORIGIN_Y    = 80,
    parameter int FOG_R       = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      pix_valid,
    input  logic                      wr_en,
    input  logic [$clog2(SIZE_Y)-1:0] wr_row,
    input  logic [SIZE_X-1:0]         wr_data,
    input  logic                      clear,
    input  logic                      fog_en,
    input  logic [$clog2(SIZE_X)-1:0] player_x,
    input  logic [$clog2(SIZE_Y)-1:0] player_y,
    output logic                      draw_wall,
    output logic                      draw_player,
    output logic                      draw_fog,
    output logic                      out_valid
);
    localparam int XW = $clog2(SIZE_X);
    localparam int YW = $clog2(SIZE_Y);

    logic [SIZE_X-1:0] maze    [SIZE_Y];
    logic [SIZE_X-1:0] visited [SIZE_Y];

    logic          s1_valid;
    logic          s1_in_range;
    logic [XW-1:0] s1_cx;
    logic [YW-1:0] s1_cy;

    // Stage 1: relative coordinate; bit 10 set means left of / above the maze
    logic [10:0] rx, ry, rxs, rys;
    logic        in_range;

    assign rx  = {1'b0, DrawX} - 11'(ORIGIN_X);
    assign ry  = {1'b0, DrawY} - 11'(ORIGIN_Y);
    assign rxs = rx >> CELL_LOG2_W;
    assign rys = ry >> CELL_LOG2_H;
    assign in_range = !rx[10] && !ry[10] &&
                      (rxs < 11'(SIZE_X)) && (rys < 11'(SIZE_Y));

    // Stage 2: cell lookup and fog distance
    logic        wall, vis, player_in, is_player, near, revealed, hit;
    logic [XW:0] dx;
    logic [YW:0] dy;

    assign wall = s1_in_range ? maze[s1_cy][s1_cx] : 1'b0;
    assign vis  = s1_in_range ? visited[s1_cy][s1_cx] : 1'b0;

    assign dx = (s1_cx >= player_x) ? ({1'b0, s1_cx} - {1'b0, player_x})
                                    : ({1'b0, player_x} - {1'b0, s1_cx});
    assign dy = (s1_cy >= player_y) ? ({1'b0, s1_cy} - {1'b0, player_y})
                                    : ({1'b0, player_y} - {1'b0, s1_cy});

    assign player_in = (player_x < XW'(SIZE_X)) && (player_y < YW'(SIZE_Y));
    assign is_player = player_in && (s1_cx == player_x) && (s1_cy == player_y);
    assign near      = (dx <= (XW+1)'(FOG_R)) && (dy <= (YW+1)'(FOG_R));
    assign revealed  = !fog_en || vis || near;
    assign hit       = s1_valid && s1_in_range;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_cx       <= '0;
            s1_cy       <= '0;
            out_valid   <= 1'b0;
            draw_wall   <= 1'b0;
            draw_player <= 1'b0;
            draw_fog    <= 1'b0;
            maze        <= '{default: '0};
            visited     <= '{default: '0};
        end else begin
            s1_valid    <= pix_valid;
            s1_in_range <= in_range;
            s1_cx       <= rxs[XW-1:0];
            s1_cy       <= rys[YW-1:0];

            out_valid   <= s1_valid;
            draw_player <= hit && is_player;
            draw_wall   <= hit && wall && revealed && !is_player;
            draw_fog    <= hit && fog_en && !revealed && !is_player;

            // clear beats both the row write and the visited set
            if (clear) begin
                maze    <= '{default: '0};
                visited <= '{default: '0};
            end else begin
                if (wr_en && (wr_row < YW'(SIZE_Y)))
                    maze[wr_row] <= wr_data;
                if (player_in)
                    visited[player_y][player_x] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_maze_render_pipe.sv
// Scoreboard bench for maze_render_pipe: directed pixels push expectations,
// a monitor pops and compares whenever out_valid is high.
module tb_maze_render_pipe;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        pix_valid = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_row = '0;
    logic [39:0] wr_data = '0;
    logic        clear = 1'b0;
    logic        fog_en = 1'b0;
    logic [5:0]  player_x = 6'd0;
    logic [4:0]  player_y = 5'd19;
    logic        draw_wall, draw_player, draw_fog, out_valid;

    localparam logic [39:0] ONES = {40{1'b1}};

    maze_render_pipe dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .pix_valid(pix_valid), .wr_en(wr_en), .wr_row(wr_row),
        .wr_data(wr_data), .clear(clear), .fog_en(fog_en),
        .player_x(player_x), .player_y(player_y),
        .draw_wall(draw_wall), .draw_player(draw_player),
        .draw_fog(draw_fog), .out_valid(out_valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic w;
        logic p;
        logic f;
        int   cyc;
        int   id;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   nid = 0;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid at cycle %0d", cyc);
            end else begin
                me = q.pop_front();
                if ({draw_wall, draw_player, draw_fog} != {me.w, me.p, me.f} ||
                    cyc - me.cyc != 2) begin
                    failures++;
                    $display("FAIL pix%0d wpf got %b%b%b lat %0d exp %b%b%b lat 2",
                             me.id, draw_wall, draw_player, draw_fog,
                             cyc - me.cyc, me.w, me.p, me.f);
                end
            end
        end else begin
            checks++;
            if (draw_wall || draw_player || draw_fog) begin
                failures++;
                $display("FAIL idle_zero got %b%b%b exp 000",
                         draw_wall, draw_player, draw_fog);
            end
        end
    end

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic drive(int x, int y, logic w, logic p, logic f);
        exp_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        pix_valid = 1'b1;
        e.w = w; e.p = p; e.f = f; e.cyc = cyc; e.id = nid;
        q.push_back(e);
        nid++;
    endtask

    task automatic pix1(int x, int y, logic w, logic p, logic f);
        step();
        drive(x, y, w, p, f);
        step();
        pix_valid = 1'b0;
        step();
    endtask

    task automatic wr(int row, logic [39:0] d);
        step();
        wr_en = 1'b1;
        wr_row = 5'(row);
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic chk(string name, logic [3:0] got, logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got %b exp %b", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        chk("reset_state", {draw_wall, draw_player, draw_fog, out_valid}, 4'b0000);
        Reset = 1'b0;

        // Row 0 all walls, full-line sweep, then the row just above the maze
        wr(0, ONES);
        for (int x = 0; x < 640; x++) begin
            step();
            drive(x, 80, 1'b1, 1'b0, 1'b0);
        end
        step();
        drive(100, 79, 1'b0, 1'b0, 1'b0);
        step();
        pix_valid = 1'b0;
        step();

        // Player highlight suppresses the wall in its own cell
        player_x = 6'd3; player_y = 5'd0;
        pix1(50, 85, 1'b0, 1'b1, 1'b0);
        pix1(66, 85, 1'b1, 1'b0, 1'b0);

        // Fog: cell (20,10) against various player positions
        wr(10, ONES);
        player_x = 6'd0; player_y = 5'd0; fog_en = 1'b1;
        pix1(328, 248, 1'b0, 1'b0, 1'b1);
        player_x = 6'd17; player_y = 5'd10;
        pix1(328, 248, 1'b0, 1'b0, 1'b1);
        player_x = 6'd18; player_y = 5'd8;
        pix1(328, 248, 1'b1, 1'b0, 1'b0);
        player_x = 6'd18; player_y = 5'd7;
        pix1(328, 248, 1'b0, 1'b0, 1'b1);
        player_x = 6'd20; player_y = 5'd10;
        step();
        player_x = 6'd0; player_y = 5'd0;
        pix1(328, 248, 1'b1, 1'b0, 1'b0);

        // clear wins over same-edge write and wipes the visited map
        fog_en = 1'b0;
        wr(5, ONES);
        pix1(8, 168, 1'b1, 1'b0, 1'b0);
        step();
        clear = 1'b1; wr_en = 1'b1; wr_row = 5'd5; wr_data = ONES;
        step();
        clear = 1'b0; wr_en = 1'b0;
        pix1(8, 168, 1'b0, 1'b0, 1'b0);
        fog_en = 1'b1;
        pix1(328, 248, 1'b0, 1'b0, 1'b1);
        fog_en = 1'b0;
        wr(25, ONES);
        pix1(8, 168, 1'b0, 1'b0, 1'b0);
        pix1(8, 232, 1'b0, 1'b0, 1'b0);

        // Write/read on the same edge sees the old row
        player_x = 6'd0; player_y = 5'd19;
        step();
        drive(8, 120, 1'b0, 1'b0, 1'b0);
        step();
        wr_en = 1'b1; wr_row = 5'd2; wr_data = ONES;
        drive(8, 120, 1'b1, 1'b0, 1'b0);
        step();
        wr_en = 1'b0;
        pix_valid = 1'b0;
        step();
        step();

        // Reset mid-stream flushes the pipe and the maze
        wr(0, ONES);
        for (int i = 0; i < 6; i++) begin
            step();
            drive(i * 16 + 3, 80, 1'b1, 1'b0, 1'b0);
        end
        step();
        Reset = 1'b1;
        DrawX = 10'd200;
        step();
        chk("reset_flush", {draw_wall, draw_player, draw_fog, out_valid}, 4'b0000);
        q.delete();
        Reset = 1'b0;
        drive(8, 80, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++) begin
            step();
            drive(i * 100, 80 + i * 32, 1'b0, 1'b0, 1'b0);
        end
        step();
        pix_valid = 1'b0;
        step();
        step();
        step();

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/maze_render_pipe.md
Name: maze_render_pipe

Overview:
- Pipelined, clocked maze pixel renderer. Replaces the per-cell combinational maze draw array.
- Holds the maze bitmap in internal registers, loaded one row per write.
- Maps the VGA pixel coordinate to a cell with a fixed 2-cycle latency.
- Adds player-cell highlight, a visited-cell map, and an optional fog-of-war mode. Sits between the VGA controller and the colour mapper.

Parameters:
- SIZE_X, 40, maze columns
- SIZE_Y, 20, maze rows
- CELL_LOG2_W, 4, log2 of cell width in pixels (16)
- CELL_LOG2_H, 4, log2 of cell height in pixels (16)
- ORIGIN_X, 0, screen X of the maze's left edge
- ORIGIN_Y, 80, screen Y of the maze's top edge
- FOG_R, 2, fog reveal radius in cells (Chebyshev distance)

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  pixel X from the VGA controller
- DrawY  in  10  pixel Y from the VGA controller
- pix_valid  in  1  DrawX/DrawY are in the active display area
- wr_en  in  1  write one maze row
- wr_row  in  $clog2(SIZE_Y)  row index to write
- wr_data  in  SIZE_X  row bitmap; bit 0 is column 0; 1 = wall
- clear  in  1  zero the maze and visited maps
- fog_en  in  1  fog-of-war mode enable
- player_x  in  $clog2(SIZE_X)  player column
- player_y  in  $clog2(SIZE_Y)  player row
- draw_wall  out  1  pixel is a visible wall
- draw_player  out  1  pixel is in the player's cell
- draw_fog  out  1  pixel is a hidden cell (fog mode only)
- out_valid  out  1  pixel_valid delayed by 2 cycles

Behaviour:
- Reset:
  - Clears the maze map, the visited map and both pipeline stages.
  - All outputs are 0 on the first edge after Reset is asserted.
  - Reset asserted mid-frame discards in-flight pixels; outputs stay 0 until 2 edges after the first post-reset pix_valid.
- Stage 1, edge k:
  - Register rx = DrawX-ORIGIN_X and ry = DrawY-ORIGIN_Y (11-bit signed) and pix_valid.
  - Register in_range = rx≥0, ry≥0, (rx>>CELL_LOG2_W)<SIZE_X and (ry>>CELL_LOG2_H)<SIZE_Y.
  - Register cx = rx>>CELL_LOG2_W and cy = ry>>CELL_LOG2_H.
- Stage 2, edge k+1:
  - Look up wall = maze[cy][cx] and vis = visited[cy][cx] from array contents before this edge.
  - Writes at edge k+1 are not seen.
  - Register the outputs. Total latency: DrawX/DrawY sampled at edge k drive outputs after edge k+1 (valid during cycle k+2).
- Output logic when out_valid=1 and in_range:
  - is_player = (cx==player_x && cy==player_y), using player values sampled at stage 2.
  - revealed = !fog_en || vis || (|cx-player_x|≤FOG_R && |cy-player_y|≤FOG_R).
  - draw_player = is_player.
  - draw_wall = wall && revealed && !is_player.
  - draw_fog = fog_en && !revealed && !is_player.
  - The three outputs are mutually exclusive.
- Out of range or pix_valid=0: draw_wall, draw_player and draw_fog are all 0; out_valid follows delayed pix_valid.
- Maze write:
  - wr_en with wr_row<SIZE_Y replaces the whole row at that edge.
  - wr_row≥SIZE_Y is ignored and no state changes.
- clear:
  - Zeroes every maze and visited bit at that edge.
  - Takes priority over a simultaneous wr_en, so the row write is dropped.
  - Does not flush the pipeline.
- Visited map:
  - Every edge with player_x<SIZE_X and player_y<SIZE_Y sets visited[player_y][player_x].
  - Out-of-range player coordinates set nothing and never produce draw_player.
  - Same-edge clear wins over the visited set.
- Player coordinates are free-running. No handshake is needed; changes take effect on the next stage-2 edge.
- Arithmetic: absolute cell difference computed in $clog2(SIZE_X)+1 bits, with no wrap-around.

Test Plan:
- Reset, write row 0 = all ones, sweep DrawX 0..639 with DrawY=80, pix_valid=1, fog off -> draw_wall=1 for every sample, exactly 2 cycles after each input; DrawY=79 -> draw_wall=0.
- Player at (3,0), row 0 all walls, pixel (DrawX=50, DrawY=85) -> draw_player=1, draw_wall=0; pixel (DrawX=66, DrawY=85) -> draw_wall=1.
- fog_en=1, player at (0,0), row 10 all walls, pixel in cell (20,10) -> draw_fog=1, draw_wall=0. Move player to (20,10) for 1 cycle, then back to (0,0) -> the same pixel gives draw_wall=1 (visited).
- Same edge: clear=1 and wr_en=1 with wr_row=5 -> row 5 reads 0 afterwards. wr_row=25 with SIZE_Y=20 -> no row changes.
- Write row 2 at edge N while a row-2 pixel reaches stage 2 at edge N -> the output shows the old value; the same pixel one cycle later shows the new value.
- Assert Reset for 1 cycle during a streaming sweep -> all outputs 0 the next cycle; resume after 2 valid pixels; the maze map reads all 0.
